// File: rtl/render_frame_sequencer_pkg.sv
// render_frame_sequencer_pkg
//   Shared types for the frame sequencer: pixel colour, triangle record,
//   host command encoding and a saturating increment helper.
package render_frame_sequencer_pkg;

    typedef logic [11:0] color12_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } vertex_t;

    // 72-bit triangle: three screen-space vertices plus flat colour.
    typedef struct packed {
        vertex_t  v0;
        vertex_t  v1;
        vertex_t  v2;
        color12_t color;
    } triangle_t;

    typedef enum logic [1:0] {
        CMD_BEGIN = 2'd0,
        CMD_TRI   = 2'd1,
        CMD_END   = 2'd2
    } seq_cmd_t;

    localparam int TRI_CNT_W   = 16;
    localparam int FRAME_CYC_W = 32;

    function automatic logic [FRAME_CYC_W-1:0] sat_inc32(input logic [FRAME_CYC_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/render_frame_sequencer_if.sv
// render_frame_sequencer_if
//   Host command stream into the frame sequencer.
//   Handshake: a command transfers on every rising clk edge where
//   cmd_valid && cmd_ready. While cmd_valid is high the host holds cmd_type,
//   cmd_fill_color and cmd_triangle stable; cmd_ready may depend on them.
//   Ports (signals):
//     cmd_valid       host -> seq   command present
//     cmd_ready       seq  -> host  command accepted this cycle
//     cmd_type        host -> seq   CMD_BEGIN / CMD_TRI / CMD_END
//     cmd_fill_color  host -> seq   fill colour (CMD_BEGIN)
//     cmd_triangle    host -> seq   triangle (CMD_TRI)
interface render_frame_sequencer_if;
    import render_frame_sequencer_pkg::*;

    logic      cmd_valid;
    logic      cmd_ready;
    seq_cmd_t  cmd_type;
    color12_t  cmd_fill_color;
    triangle_t cmd_triangle;

    modport master (output cmd_valid, cmd_type, cmd_fill_color, cmd_triangle,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_type, cmd_fill_color, cmd_triangle,
                    output cmd_ready);
endinterface

// File: rtl/render_frame_sequencer_busy_settle_timer.sv
// busy_settle_timer
//   Decides when the renderer has drained. Both counters are held at zero
//   while clear is high and run while it is low.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     clear      hold counters at zero (sequencer not draining)
//     busy       renderer busy
//     settled    busy low now and for the previous SETTLE_CYCLES-1 cycles
//     timed_out  this is the DRAIN_TIMEOUT-th cycle since clear dropped
module busy_settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic settled,
    output logic timed_out
);
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(DRAIN_TIMEOUT);

    // settle_cnt: number of consecutive low cycles before the current one,
    // saturating once the current low cycle would complete the window.
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            settle_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (busy)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_LAST)
                settle_cnt <= settle_cnt + 1'b1;
            if (timeout_cnt != TIMEOUT_MAX)
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    assign settled   = !busy && (settle_cnt == SETTLE_LAST);
    assign timed_out = (timeout_cnt >= TIMEOUT_LAST);
endmodule

// File: rtl/render_frame_sequencer.sv
// render_frame_sequencer
//   Frame-level controller in front of render_manager. Per frame: latch the
//   fill colour, pulse fill_valid then begin_frame, stream triangles, wait for
//   the renderer to drain, run the swap handshake and pulse frame_done.
//   Optional feature macro: RENDER_SEQ_STATS_EN adds stat_tri_count and
//   stat_frame_cycles (both refreshed at frame_done).
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     cmd                 host command stream (slave side)
//     rm_fill_color/valid fill colour to render_manager
//     rm_begin_frame      frame start pulse (cycle after fill_valid)
//     rm_triangle/_valid/_ready  triangle stream to render_manager
//     rm_busy             render_manager busy
//     swap_req/swap_ack   framebuffer swap handshake
//     frame_active        BEGIN accepted, frame_done not yet reached
//     frame_done          1-cycle completion pulse
//     err_protocol, err_timeout, warn_empty  sticky status
//     dbg_state           current FSM state encoding
module render_frame_sequencer
    import render_frame_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    render_frame_sequencer_if.slave   cmd,
    output color12_t                  rm_fill_color,
    output logic                      rm_fill_valid,
    output logic                      rm_begin_frame,
    output triangle_t                 rm_triangle,
    output logic                      rm_triangle_valid,
    input  logic                      rm_triangle_ready,
    input  logic                      rm_busy,
    output logic                      swap_req,
    input  logic                      swap_ack,
    output logic                      frame_active,
    output logic                      frame_done,
    output logic                      err_protocol,
    output logic                      err_timeout,
    output logic                      warn_empty,
`ifdef RENDER_SEQ_STATS_EN
    output logic [TRI_CNT_W-1:0]      stat_tri_count,
    output logic [FRAME_CYC_W-1:0]    stat_frame_cycles,
`endif
    output logic [2:0]                dbg_state
);
    typedef enum logic [2:0] {
        IDLE, LOAD_FILL, START, STREAM, DRAIN, SWAP
    } state_t;

    state_t   state, state_next;
    color12_t fill_color_q;
    logic     begin_accept, proto_err_set, tri_fire;
    logic     settled, timed_out, tri_none;
    logic     swap_done;

    busy_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state != DRAIN),
        .busy      (rm_busy),
        .settled   (settled),
        .timed_out (timed_out)
    );

    always_comb begin
        state_next        = state;
        cmd.cmd_ready     = 1'b0;
        rm_triangle_valid = 1'b0;
        begin_accept      = 1'b0;
        proto_err_set     = 1'b0;
        tri_fire          = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_type == CMD_BEGIN) begin
                        begin_accept = 1'b1;
                        state_next   = LOAD_FILL;
                    end else begin
                        proto_err_set = 1'b1;
                    end
                end
            end
            LOAD_FILL: state_next = START;
            START:     state_next = STREAM;
            STREAM: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_type == CMD_TRI) begin
                        rm_triangle_valid = 1'b1;
                        cmd.cmd_ready     = rm_triangle_ready;
                        tri_fire          = rm_triangle_ready;
                    end else if (cmd.cmd_type == CMD_END) begin
                        cmd.cmd_ready = 1'b1;
                        state_next    = DRAIN;
                    end else begin
                        // Nested BEGIN (or unused encoding): swallow it.
                        cmd.cmd_ready = 1'b1;
                        proto_err_set = 1'b1;
                    end
                end
            end
            DRAIN: if (settled || timed_out) state_next = SWAP;
            SWAP:  if (swap_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign swap_done = (state == SWAP) && swap_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fill_color_q <= '0;
            frame_done   <= 1'b0;
            err_protocol <= 1'b0;
            err_timeout  <= 1'b0;
            warn_empty   <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= swap_done;
            if (begin_accept)
                fill_color_q <= cmd.cmd_fill_color;
            if (proto_err_set)
                err_protocol <= 1'b1;
            // A drain that settles on its last allowed cycle is not a timeout.
            if (state == DRAIN && timed_out && !settled)
                err_timeout <= 1'b1;
            if (state == DRAIN && tri_none)
                warn_empty <= 1'b1;
        end
    end

`ifdef RENDER_SEQ_STATS_EN
    logic [TRI_CNT_W-1:0]   tri_cnt;
    logic [FRAME_CYC_W-1:0] frame_cyc;   // cycles elapsed since BEGIN acceptance

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_cnt           <= '0;
            frame_cyc         <= '0;
            stat_tri_count    <= '0;
            stat_frame_cycles <= '0;
        end else begin
            if (begin_accept) begin
                tri_cnt   <= '0;
                frame_cyc <= FRAME_CYC_W'(1);
            end else begin
                if (tri_fire && tri_cnt != '1)
                    tri_cnt <= tri_cnt + 1'b1;
                if (state != IDLE)
                    frame_cyc <= sat_inc32(frame_cyc);
            end
            if (swap_done) begin
                stat_tri_count    <= tri_cnt;
                stat_frame_cycles <= sat_inc32(frame_cyc);
            end
        end
    end
    assign tri_none = (tri_cnt == '0);
`else
    // Only "any triangle this frame" is needed for warn_empty.
    logic tri_seen;
    always_ff @(posedge clk) begin
        if (rst || begin_accept)
            tri_seen <= 1'b0;
        else if (tri_fire)
            tri_seen <= 1'b1;
    end
    assign tri_none = !tri_seen;
`endif

    assign rm_fill_color  = fill_color_q;
    assign rm_fill_valid  = (state == LOAD_FILL);
    assign rm_begin_frame = (state == START);
    assign rm_triangle    = cmd.cmd_triangle;
    assign swap_req       = (state == SWAP);
    assign frame_active   = (state != IDLE);
    assign dbg_state      = state;
endmodule

// File: tb/tb_render_frame_sequencer.sv
module tb_render_frame_sequencer;
    import render_frame_sequencer_pkg::*;

    localparam int W = 75;
    localparam logic [2:0] K_FILL  = 3'd1;
    localparam logic [2:0] K_BEGIN = 3'd2;
    localparam logic [2:0] K_TRI   = 3'd3;
    localparam logic [2:0] K_DONE  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rm_triangle_ready = 1'b1;
    logic rm_busy = 1'b0;
    logic swap_ack = 1'b0;
    color12_t  rm_fill_color;
    triangle_t rm_triangle;
    logic rm_fill_valid, rm_begin_frame, rm_triangle_valid, swap_req;
    logic frame_active, frame_done, err_protocol, err_timeout, warn_empty;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic fill_prev = 1'b0;

    render_frame_sequencer_if bus();

    render_frame_sequencer #(.SETTLE_CYCLES(2), .DRAIN_TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd               (bus),
        .rm_fill_color     (rm_fill_color),
        .rm_fill_valid     (rm_fill_valid),
        .rm_begin_frame    (rm_begin_frame),
        .rm_triangle       (rm_triangle),
        .rm_triangle_valid (rm_triangle_valid),
        .rm_triangle_ready (rm_triangle_ready),
        .rm_busy           (rm_busy),
        .swap_req          (swap_req),
        .swap_ack          (swap_ack),
        .frame_active      (frame_active),
        .frame_done        (frame_done),
        .err_protocol      (err_protocol),
        .err_timeout       (err_timeout),
        .warn_empty        (warn_empty),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [2:0] k, input logic [71:0] p);
        return {k, p};
    endfunction

    function automatic triangle_t mk_tri(input int a);
        triangle_t t;
        t.v0.x  = 10'(a);      t.v0.y = 10'(a + 1);
        t.v1.x  = 10'(a + 100); t.v1.y = 10'(a + 2);
        t.v2.x  = 10'(a + 3);  t.v2.y = 10'(a + 200);
        t.color = 12'(a * 7);
        return t;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic observe(input string nm, input logic [W-1:0] obs);
        logic [W-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event %0h, expected none", nm, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", nm, obs, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            fill_prev = 1'b0;
        end else begin
            if (rm_fill_valid)
                observe("fill", ev(K_FILL, {60'd0, rm_fill_color}));
            if (rm_begin_frame)
                observe("begin_frame", ev(K_BEGIN, {71'd0, fill_prev}));
            if (rm_triangle_valid && rm_triangle_ready)
                observe("triangle", ev(K_TRI, rm_triangle));
            if (frame_done)
                observe("frame_done", ev(K_DONE, {69'd0, err_protocol, err_timeout, warn_empty}));
            fill_prev = rm_fill_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_cmd(input seq_cmd_t t, input color12_t c, input triangle_t tr);
        int n = 0;
        logic acc;
        bus.cmd_valid = 1'b1;
        bus.cmd_type = t;
        bus.cmd_fill_color = c;
        bus.cmd_triangle = tr;
        forever begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL cmd_accept: got no ready after %0d cycles, expected acceptance", n);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic begin_frame_exp(input color12_t c);
        exp_q.push_back(ev(K_FILL, {60'd0, c}));
        exp_q.push_back(ev(K_BEGIN, 72'd1));
        send_cmd(CMD_BEGIN, c, '0);
    endtask

    task automatic tri_exp(input triangle_t tr);
        exp_q.push_back(ev(K_TRI, tr));
        send_cmd(CMD_TRI, 12'h0, tr);
    endtask

    task automatic end_exp(input logic p, input logic t, input logic w);
        exp_q.push_back(ev(K_DONE, {69'd0, p, t, w}));
        send_cmd(CMD_END, 12'h0, '0);
    endtask

    // Started on the first DRAIN cycle; rm_busy follows pat bit n in DRAIN
    // cycle n+1. Counts cycles until swap_req is seen; ends at that negedge.
    task automatic drain_expect(input logic [31:0] pat, input int exp_n, input string nm);
        int n = 0;
        forever begin
            rm_busy = (n < 32) ? pat[n] : 1'b0;
            @(negedge clk);
            n++;
            if (swap_req || n > 100) break;
            @(posedge clk); #1;
        end
        rm_busy = 1'b0;
        check(nm, W'(n), W'(exp_n));
    endtask

    // Raises swap_ack d cycles after swap_req was seen, then checks the done cycle.
    task automatic swap_after(input int d);
        repeat (d) @(posedge clk);
        #1 swap_ack = 1'b1;
        @(posedge clk); #1;
        swap_ack = 1'b0;
        @(negedge clk);
        check("done_cycle", {frame_done, swap_req, frame_active}, 3'b100);
        @(posedge clk); #1;
    endtask

    task automatic tri_step(input triangle_t tr, input logic rdy, input logic exp_ready);
        bus.cmd_valid = 1'b1;
        bus.cmd_type = CMD_TRI;
        bus.cmd_triangle = tr;
        rm_triangle_ready = rdy;
        @(negedge clk);
        check("bp_ready", {rm_triangle_valid, bus.cmd_ready}, {1'b1, exp_ready});
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string nm);
        check(nm, {rm_fill_valid, rm_begin_frame, rm_triangle_valid, swap_req, frame_active,
                   frame_done, err_protocol, err_timeout, warn_empty, rm_fill_color, dbg_state},
              '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type = CMD_BEGIN;
        bus.cmd_fill_color = '0;
        bus.cmd_triangle = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_state");
        check("idle_ready", W'(bus.cmd_ready), W'(1));
        @(posedge clk); #1;

        // Normal frame
        begin_frame_exp(12'hF00);
        tri_exp(mk_tri(10));
        tri_exp(mk_tri(20));
        tri_exp(mk_tri(30));
        end_exp(1'b0, 1'b0, 1'b0);
        drain_expect(32'h0000_001F, 8, "normal_drain_lat");
        swap_after(4);

        // Backpressure: ready 1,0,1 on TRI, then 0 while END is accepted
        begin_frame_exp(12'h0F0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(ev(K_TRI, mk_tri(40)));
        exp_q.push_back(ev(K_TRI, mk_tri(50)));
        tri_step(mk_tri(40), 1'b1, 1'b1);
        tri_step(mk_tri(50), 1'b0, 1'b0);
        tri_step(mk_tri(50), 1'b1, 1'b1);
        bus.cmd_valid = 1'b0;
        rm_triangle_ready = 1'b0;
        end_exp(1'b0, 1'b0, 1'b0);
        rm_triangle_ready = 1'b1;
        drain_expect(32'h0, 3, "min_drain_lat");
        swap_after(1);

        // Settle glitch: busy 0,1,0,0 in DRAIN
        begin_frame_exp(12'h0A5);
        tri_exp(mk_tri(60));
        end_exp(1'b0, 1'b0, 1'b0);
        drain_expect(32'b0010, 5, "settle_glitch_lat");
        swap_after(1);

        // Timeout: busy stuck high, DRAIN_TIMEOUT=16
        begin_frame_exp(12'h123);
        tri_exp(mk_tri(70));
        end_exp(1'b0, 1'b1, 1'b0);
        drain_expect(32'hFFFF_FFFF, 17, "timeout_lat");
        check("timeout_flag", W'(err_timeout), W'(1));
        swap_after(2);

        // Clear flags, then protocol violations
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_clear");
        @(posedge clk); #1;
        send_cmd(CMD_TRI, 12'h0, mk_tri(80));
        @(negedge clk);
        check("proto_after_tri", {err_protocol, frame_active}, 2'b10);
        @(posedge clk); #1;
        begin_frame_exp(12'h00F);
        send_cmd(CMD_BEGIN, 12'hABC, '0);
        end_exp(1'b1, 1'b0, 1'b1);
        drain_expect(32'h0, 3, "proto_drain_lat");
        swap_after(1);
        check("proto_sticky", W'(err_protocol), W'(1));

        // Reset while swap_req is high
        begin_frame_exp(12'h456);
        tri_exp(mk_tri(90));
        send_cmd(CMD_END, 12'h0, '0);
        drain_expect(32'h0, 3, "pre_reset_drain");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_mid_swap");
        @(posedge clk); #1;

        // Empty frame after reset
        begin_frame_exp(12'h789);
        end_exp(1'b0, 1'b0, 1'b1);
        drain_expect(32'h0, 3, "empty_drain_lat");
        swap_after(1);
        check("warn_empty", {err_protocol, err_timeout, warn_empty}, 3'b001);

        repeat (4) @(posedge clk);
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
